// File: rtl/crypt_reg_pkg.sv
// rtl/crypt_reg_pkg.sv - register offsets, CTRL/STATUS bit indices and channel FSM encoding
package crypt_reg_pkg;

    localparam logic [3:0] OFF_CTRL   = 4'd0;
    localparam logic [3:0] OFF_STATUS = 4'd1;
    localparam logic [3:0] OFF_SAR    = 4'd2;
    localparam logic [3:0] OFF_DAR    = 4'd3;
    localparam logic [3:0] OFF_BSR    = 4'd4;
    localparam logic [3:0] OFF_KEY0   = 4'd8;

    localparam int CTRL_EN     = 0;
    localparam int CTRL_CMD_LO = 1;
    localparam int CTRL_CMD_HI = 2;
    localparam int CTRL_START  = 3;
    localparam int CTRL_IRQ_EN = 4;

    localparam int ST_BUSY = 0;
    localparam int ST_DONE = 1;
    localparam int ST_ERR  = 2;

    typedef enum logic {
        CH_IDLE = 1'b0,
        CH_BUSY = 1'b1
    } ch_state_e;

endpackage

// File: rtl/crypt_reg_channel.sv
// rtl/crypt_reg_channel.sv - one channel: config regs, IDLE/BUSY FSM, W1C status
module crypt_reg_channel
    import crypt_reg_pkg::*;
#(
    parameter int KEY_WORDS = 6,
    parameter int AFIELD_W  = 13
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_en,
    input  logic [3:0]              wr_off,
    input  logic [31:0]             wr_data,
    input  logic [3:0]              rd_off,
    output logic [31:0]             rd_data,
    input  logic                    ch_done,
    input  logic                    ch_err,
    output logic                    enable,
    output logic [1:0]              cmd,
    output logic [KEY_WORDS*32-1:0] key,
    output logic [AFIELD_W-1:0]     sar,
    output logic [AFIELD_W-1:0]     dar,
    output logic [AFIELD_W-1:0]     bsr,
    output logic                    start,
    output logic                    irq
);

    ch_state_e             state_q, state_d;
    logic                  enable_q, enable_d;
    logic                  irq_en_q, irq_en_d;
    logic [1:0]            cmd_q, cmd_d;
    logic [AFIELD_W-1:0]   sar_q, sar_d;
    logic [AFIELD_W-1:0]   dar_q, dar_d;
    logic [AFIELD_W-1:0]   bsr_q, bsr_d;
    logic [31:0]           key_q [KEY_WORDS];
    logic [31:0]           key_d [KEY_WORDS];
    logic                  done_q, done_d;
    logic                  err_q, err_d;
    logic                  start_q, start_d;

    logic                  locked;
    logic                  wr_ctrl;
    logic                  wr_status;
    logic                  start_req;
    logic                  done_set;
    logic                  err_set;

    // Config write decode; ENABLE/IRQ_EN stay writable while busy, the rest is locked
    always_comb begin
        locked    = (state_q == CH_BUSY);
        wr_ctrl   = wr_en && (wr_off == OFF_CTRL);
        wr_status = wr_en && (wr_off == OFF_STATUS);
        enable_d  = enable_q;
        irq_en_d  = irq_en_q;
        cmd_d     = cmd_q;
        sar_d     = sar_q;
        dar_d     = dar_q;
        bsr_d     = bsr_q;
        key_d     = key_q;
        if (wr_ctrl) begin
            enable_d = wr_data[CTRL_EN];
            irq_en_d = wr_data[CTRL_IRQ_EN];
            if (!locked) begin
                cmd_d = wr_data[CTRL_CMD_HI:CTRL_CMD_LO];
            end
        end
        if (wr_en && !locked) begin
            if (wr_off == OFF_SAR) sar_d = wr_data[AFIELD_W-1:0];
            if (wr_off == OFF_DAR) dar_d = wr_data[AFIELD_W-1:0];
            if (wr_off == OFF_BSR) bsr_d = wr_data[AFIELD_W-1:0];
            for (int k = 0; k < KEY_WORDS; k++) begin
                if (wr_off == 4'(int'(OFF_KEY0) + k)) key_d[k] = wr_data;
            end
        end
        // A START written together with ENABLE=0 is ignored entirely
        start_req = wr_ctrl && wr_data[CTRL_START] && enable_d;
    end

    // Channel FSM next state; an error pulse and a done pulse both return to idle
    always_comb begin
        state_d = state_q;
        case (state_q)
            CH_IDLE: if (start_req) state_d = CH_BUSY;
            CH_BUSY: if (ch_err || ch_done) state_d = CH_IDLE;
            default: state_d = CH_IDLE;
        endcase
    end

    // FSM outputs: start pulse, status set/clear with set taking priority over W1C
    always_comb begin
        start_d  = (state_q == CH_IDLE) && start_req;
        done_set = locked && ch_done && !ch_err;
        err_set  = locked && (ch_err || start_req);
        done_d   = done_q;
        err_d    = err_q;
        if (wr_status && wr_data[ST_DONE]) done_d = 1'b0;
        if (wr_status && wr_data[ST_ERR])  err_d  = 1'b0;
        if (done_set) done_d = 1'b1;
        if (err_set)  err_d  = 1'b1;
    end

    // Read data built from next-state values so a same-cycle write is visible
    always_comb begin
        rd_data = '0;
        case (rd_off)
            OFF_CTRL: begin
                rd_data[CTRL_EN]                 = enable_d;
                rd_data[CTRL_CMD_HI:CTRL_CMD_LO] = cmd_d;
                rd_data[CTRL_IRQ_EN]             = irq_en_d;
            end
            OFF_STATUS: begin
                rd_data[ST_BUSY] = (state_d == CH_BUSY);
                rd_data[ST_DONE] = done_d;
                rd_data[ST_ERR]  = err_d;
            end
            OFF_SAR: rd_data[AFIELD_W-1:0] = sar_d;
            OFF_DAR: rd_data[AFIELD_W-1:0] = dar_d;
            OFF_BSR: rd_data[AFIELD_W-1:0] = bsr_d;
            default: begin
                for (int k = 0; k < KEY_WORDS; k++) begin
                    if (rd_off == 4'(int'(OFF_KEY0) + k)) rd_data = key_d[k];
                end
            end
        endcase
    end

    // Channel register state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= CH_IDLE;
            enable_q <= 1'b0;
            irq_en_q <= 1'b0;
            cmd_q    <= '0;
            sar_q    <= '0;
            dar_q    <= '0;
            bsr_q    <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            start_q  <= 1'b0;
            for (int k = 0; k < KEY_WORDS; k++) key_q[k] <= '0;
        end else begin
            state_q  <= state_d;
            enable_q <= enable_d;
            irq_en_q <= irq_en_d;
            cmd_q    <= cmd_d;
            sar_q    <= sar_d;
            dar_q    <= dar_d;
            bsr_q    <= bsr_d;
            done_q   <= done_d;
            err_q    <= err_d;
            start_q  <= start_d;
            key_q    <= key_d;
        end
    end

    // Flatten key words, word 0 at the LSBs
    always_comb begin
        key = '0;
        for (int k = 0; k < KEY_WORDS; k++) key[k*32 +: 32] = key_q[k];
    end

    assign enable = enable_q;
    assign cmd    = cmd_q;
    assign sar    = sar_q;
    assign dar    = dar_q;
    assign bsr    = bsr_q;
    assign start  = start_q;
    assign irq    = irq_en_q && (done_q || err_q);

endmodule

// File: rtl/crypt_reg_bank.sv
// rtl/crypt_reg_bank.sv - AHB-Lite register bank for a multi-channel crypto engine
module crypt_reg_bank
    import crypt_reg_pkg::*;
#(
    parameter int NUM_CH    = 2,
    parameter int KEY_WORDS = 6,
    parameter int AFIELD_W  = 13,
    parameter int HADDR_W   = 20
) (
    input  logic                           AHB_HCLK,
    input  logic                           AHB_HRESET,
    input  logic                           AHB_HSEL,
    input  logic [HADDR_W-1:0]             AHB_HADDR,
    input  logic [1:0]                     AHB_HTRANS,
    input  logic                           AHB_HWRITE,
    input  logic                           AHB_HREADY,
    input  logic [31:0]                    AHB_HWDATA,
    input  logic                           SET_STR,
    output logic [31:0]                    AHB_HRDATA,
    output logic                           AHB_HREADYOUT,
    output logic                           AHB_HRESP,
    output logic [NUM_CH-1:0]              ENABLE,
    output logic [2*NUM_CH-1:0]            CMDR,
    output logic [NUM_CH*KEY_WORDS*32-1:0] KEY,
    output logic [NUM_CH*AFIELD_W-1:0]     SAR_ADDR,
    output logic [NUM_CH*AFIELD_W-1:0]     DAR_ADDR,
    output logic [NUM_CH*AFIELD_W-1:0]     BSR,
    output logic [NUM_CH-1:0]              CH_START,
    input  logic [NUM_CH-1:0]              CH_DONE,
    input  logic [NUM_CH-1:0]              CH_ERR,
    output logic                           CRYPT_INTR
);

    logic        dp_valid_q, dp_valid_d;
    logic        dp_write_q, dp_write_d;
    logic [1:0]  dp_ch_q, dp_ch_d;
    logic [3:0]  dp_off_q, dp_off_d;
    logic [31:0] hrdata_q, hrdata_d;
    logic        intr_q, intr_d;

    logic        addr_accept;
    logic        wr_commit;
    logic [31:0] rd_mux;
    logic [31:0] ch_rd [NUM_CH];
    logic [NUM_CH-1:0] ch_irq;
    logic        unused_bits;

    // Address phase capture; the write commits in the following data phase when SET_STR is high
    always_comb begin
        addr_accept = AHB_HSEL && AHB_HTRANS[1] && AHB_HREADY;
        dp_valid_d  = addr_accept;
        dp_write_d  = AHB_HWRITE;
        dp_ch_d     = AHB_HADDR[5:4];
        dp_off_d    = AHB_HADDR[3:0];
        wr_commit   = dp_valid_q && dp_write_q && SET_STR;
    end

    // Read mux over channels; out-of-range channels read zero; interrupt OR
    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (AHB_HADDR[5:4] == 2'(i)) rd_mux = ch_rd[i];
        end
        hrdata_d = (addr_accept && !AHB_HWRITE) ? rd_mux : '0;
        intr_d   = |ch_irq;
    end

    // Bus pipeline, read data and interrupt registers
    always_ff @(posedge AHB_HCLK or posedge AHB_HRESET) begin
        if (AHB_HRESET) begin
            dp_valid_q <= 1'b0;
            dp_write_q <= 1'b0;
            dp_ch_q    <= '0;
            dp_off_q   <= '0;
            hrdata_q   <= '0;
            intr_q     <= 1'b0;
        end else begin
            dp_valid_q <= dp_valid_d;
            dp_write_q <= dp_write_d;
            dp_ch_q    <= dp_ch_d;
            dp_off_q   <= dp_off_d;
            hrdata_q   <= hrdata_d;
            intr_q     <= intr_d;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        crypt_reg_channel #(
            .KEY_WORDS (KEY_WORDS),
            .AFIELD_W  (AFIELD_W)
        ) u_ch (
            .clk     (AHB_HCLK),
            .rst     (AHB_HRESET),
            .wr_en   (wr_commit && (dp_ch_q == 2'(i))),
            .wr_off  (dp_off_q),
            .wr_data (AHB_HWDATA),
            .rd_off  (AHB_HADDR[3:0]),
            .rd_data (ch_rd[i]),
            .ch_done (CH_DONE[i]),
            .ch_err  (CH_ERR[i]),
            .enable  (ENABLE[i]),
            .cmd     (CMDR[2*i +: 2]),
            .key     (KEY[i*KEY_WORDS*32 +: KEY_WORDS*32]),
            .sar     (SAR_ADDR[i*AFIELD_W +: AFIELD_W]),
            .dar     (DAR_ADDR[i*AFIELD_W +: AFIELD_W]),
            .bsr     (BSR[i*AFIELD_W +: AFIELD_W]),
            .start   (CH_START[i]),
            .irq     (ch_irq[i])
        );
    end

    assign AHB_HRDATA    = hrdata_q;
    assign AHB_HREADYOUT = 1'b1;
    assign AHB_HRESP     = 1'b0;
    assign CRYPT_INTR    = intr_q;
    assign unused_bits   = ^{AHB_HADDR[HADDR_W-1:6], AHB_HTRANS[0]};

endmodule
